// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: front-end fetch stage.
//   Issues sequential PCs to instruction memory under a credit limit, buffers the
//   returned words in a DEPTH-entry in-order queue, and presents the head to decode.
//   A redirect flushes the queue and drops every response that is still in flight.
// Ports:
//   clk, rst                         core clock, async active-high reset
//   imem_req_valid/ready/addr        fetch request channel (addr = current PC)
//   imem_resp_valid/data             in-order responses, no backpressure
//   redirect_valid/redirect_pc       single-cycle redirect to a new PC
//   dec_valid/ready/inst/pc          head entry toward decode (NOP/0 when empty)
module inst_fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h13
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [63:0] dec_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]             pc;
  logic [CW-1:0]           occ, outst, disc;
  logic [DEPTH-1:0][31:0]  q_inst;
  logic [DEPTH-1:0][63:0]  q_pc;
  logic [PW-1:0]           q_head, q_tail;
  // PCs of live (non-discarded) requests, in issue order
  logic [DEPTH-1:0][63:0]  f_pc;
  logic [PW-1:0]           f_head, f_tail;

  logic [CW:0]   credit;
  logic [63:0]   redir_aligned;
  logic          req_fire, push, pop, resp_drop;

  assign redir_aligned = redirect_pc & ~64'h3;

  // In-flight requests (including stale ones) reserve a queue slot, so a
  // response can always be written without checking for space.
  assign credit         = {1'b0, occ} + {1'b0, outst};
  assign imem_req_valid = !rst && (credit < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign dec_valid = (occ != '0);
  assign dec_inst  = dec_valid ? q_inst[q_head] : NOP_INST;
  assign dec_pc    = dec_valid ? q_pc[q_head]   : 64'h0;
  assign pop       = dec_valid && dec_ready;

  // A response in a redirect cycle is always stale.
  assign push      = imem_resp_valid && (disc == '0) && !redirect_valid;
  assign resp_drop = imem_resp_valid && (disc != '0) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      occ    <= '0;
      outst  <= '0;
      disc   <= '0;
      q_head <= '0;
      q_tail <= '0;
      f_head <= '0;
      f_tail <= '0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        pc     <= redir_aligned;
        occ    <= '0;
        q_head <= '0;
        q_tail <= '0;
        f_head <= '0;
        f_tail <= '0;
        // everything still outstanding after this cycle belongs to the old path
        disc   <= outst - CW'(imem_resp_valid);
      end else begin
        if (req_fire) begin
          pc     <= pc + 64'd4;
          f_tail <= f_tail + PW'(1);
        end
        if (resp_drop) disc <= disc - CW'(1);
        if (push) begin
          q_tail <= q_tail + PW'(1);
          f_head <= f_head + PW'(1);
        end
        if (pop) q_head <= q_head + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; validity comes from the pointers/counters.
  always_ff @(posedge clk) begin
    if (req_fire && !redirect_valid) f_pc[f_tail] <= pc;
    if (push) begin
      q_inst[q_tail] <= imem_resp_data;
      q_pc[q_tail]   <= f_pc[f_head];
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ == CW'(DEPTH)) && !pop));

endmodule
